sine_stream_ctrl: RTL and testbench
===================================

# sine_stream_ctrl

Sequencing controller for the sine-wave playback path. Once per accepted `tick` it fetches one 32-bit sample from the 64-entry synchronous sine ROM, loads it into a parallel-to-serial register and shifts it out MSB-first. The serial framing signals (`SO`, `SI_en`, `soc`) go to the FPGA pins. The block sits between the tick generator and the ROM/pin interface. It replaces free-running address stepping with start/stop control, address wrap and overrun reporting.

## Interface
Parameters:
- `WORD_W`, 32: sample width, equal to the ROM data width.
- `ADDR_W`, 6: ROM address width, covering 64 entries.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle sample-rate strobe.
- `start`  in  1  one-cycle pulse; arms playback from address 0.
- `stop`  in  1  one-cycle pulse; ends playback after the current word.
- `phase_inc`  in  8  phase step; present only with `SINE_PHASE_INC_EN`.
- `rom_en`  out  1  ROM read enable.
- `rom_addr`  out  `ADDR_W`  ROM address.
- `rom_data`  in  `WORD_W`  ROM output, valid one cycle after `rom_en`.
- `SO`  out  1  serial data, MSB first.
- `SI_en`  out  1  high while a data bit is valid on `SO`.
- `soc`  out  1  one-cycle start-of-conversion pulse, coincident with the first bit.
- `busy`  out  1  high in FETCH, WAIT and SHIFT.
- `wrap`  out  1  one-cycle pulse when the address rolls over.
- `overrun`  out  1  sticky flag: a `tick` arrived while busy.

## Operation
- States: IDLE, ARMED, FETCH, WAIT, SHIFT.
- IDLE:
  - `start` -> ARMED; the address/phase register is cleared and `overrun` is cleared.
  - `tick` is ignored.
- ARMED:
  - `tick` -> FETCH.
  - `stop` -> IDLE.
- FETCH:
  - `rom_en`=1 and `rom_addr` = current address, for one cycle.
  - The address advances on exit from FETCH -> WAIT.
- WAIT:
  - Absorbs the ROM latency.
  - `rom_data` is captured into the shift register at the end of the cycle -> SHIFT.
- SHIFT:
  - 32 cycles; `SO` = shift register bit 31, then the register shifts left with 0 fill.
  - A 5-bit bit counter runs 0..31.
  - After bit 31: -> IDLE if a stop is pending, else -> ARMED.
- Address step:
  - Default: address + 1, modulo 64.
  - `wrap` pulses in the cycle the address register goes 63 -> 0.
- Boundary conditions:
  - `start` and `stop` in the same cycle: `stop` wins, and the block stays in or returns to IDLE.
  - `start` while ARMED or busy: ignored.
  - `stop` while busy: latched as stop-pending. The word always completes; `SO` is never truncated.
  - `tick` while busy: `overrun` is set and the tick is dropped, with no queueing.
  - `tick` and `stop` in the same cycle in ARMED: `stop` wins, and no fetch occurs.
  - `rst` mid-word: immediate return to IDLE with all outputs at their reset values; the partial word is discarded.

## Timing
- Reset values:
  - `rom_en`, `SO`, `SI_en`, `soc`, `busy`, `wrap`, `overrun`: all 0.
  - `rom_addr`: 0.
  - State: IDLE.
  - Shift register and bit counter: 0.
- All outputs are registered.
- Cycle sequence for a `tick` sampled in ARMED at cycle T:
  - `rom_en` high at T+1.
  - Data captured at the end of T+2.
  - `soc`=1 and `SI_en`=1 at T+3, with bit 31 on `SO`.
  - Bit 0 on `SO` at T+34, with `SI_en`=1.
  - At T+35: ARMED, `SI_en`=0, `SO`=0.
- Ticks: the minimum spacing for overrun-free operation is 35 cycles; a `tick` at T+35 is accepted.
- `busy` is high from T+1 through T+34.

## Configuration
- `SINE_PHASE_INC_EN` defined:
  - An 8-bit phase accumulator replaces the address counter; `rom_addr` = accumulator[7:2].
  - The accumulator adds `phase_inc` on exit from FETCH, and `phase_inc` is sampled in that cycle.
  - `wrap` pulses on accumulator carry-out.
- Not defined:
  - There is no `phase_inc` port.
  - The 6-bit counter steps by 1, as above.

## Structure
- Shared package/include `sine_ctrl_pkg` holds:
  - The state encoding constants.
  - `WORD_W`, `ADDR_W`, `BIT_CNT_W`=5.
  - The phase accumulator width (8).
- Sub-module `sine_piso`:
  - A 32-bit load/shift register with bit counter.
  - Outputs: `SO`, `SI_en`, `soc`, `last_bit`.
- The FSM and address logic stay in the top level.

## Test plan
- Reset then `start`, ROM[0]=32'hA5A5_0001, `tick` at T -> `rom_en`@T+1 with addr 0; `soc`@T+3; `SO` sequence 1,0,1,0,… ending with 1 at T+34; `SI_en` high for exactly 32 cycles.
- 64 ticks spaced 40 cycles -> addresses 0..63 in order; `wrap` pulses once, after the fetch of 63; next fetch is addr 0.
- `tick` at T+10 within a word -> `overrun`=1 sticky, that tick produces no fetch; the next `start` from IDLE clears `overrun`.
- `stop` at T+20 -> word completes through T+34; state IDLE at T+35; a later `tick` causes no `rom_en`.
- `rst` at T+15 -> the next cycle has all outputs 0 and state IDLE; `start` then `tick` replays from addr 0.
- With `SINE_PHASE_INC_EN` and `phase_inc`=8 -> addresses 0,2,4,…; `wrap` after 32 fetches.

Source files
------------

// File: rtl/sine_ctrl_pkg.sv
// Shared constants and FSM state encoding for the sine playback controller.
package sine_ctrl_pkg;
  localparam int WORD_W    = 32;
  localparam int ADDR_W    = 6;
  localparam int BIT_CNT_W = 5;
  localparam int PHASE_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_SHIFT = 3'd4
  } state_e;
endpackage

// File: rtl/sine_piso.sv
// Load/shift register emitting one word MSB-first with framing strobes.
module sine_piso
  import sine_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic         SO,
  output logic         SI_en,
  output logic         soc,
  output logic         last_bit
);
  logic [W-1:0]         sr_q;
  logic [BIT_CNT_W-1:0] cnt_q;
  logic                 en_q;
  logic                 soc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      en_q  <= 1'b0;
      soc_q <= 1'b0;
    end else if (load_i) begin
      sr_q  <= data_i;
      cnt_q <= '0;
      en_q  <= 1'b1;
      soc_q <= 1'b1;
    end else begin
      soc_q <= 1'b0;
      if (en_q) begin
        // Zero fill leaves SO low once the last bit has gone out.
        sr_q  <= {sr_q[W-2:0], 1'b0};
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == '1) en_q <= 1'b0;
      end
    end
  end

  assign SO       = sr_q[W-1];
  assign SI_en    = en_q;
  assign soc      = soc_q;
  assign last_bit = en_q && (cnt_q == '1);
endmodule

// File: rtl/sine_stream_ctrl.sv
// Tick-driven ROM fetch and serial playback sequencer.
// Optional feature macro: SINE_PHASE_INC_EN (8-bit phase accumulator addressing).
module sine_stream_ctrl
  import sine_ctrl_pkg::*;
#(
  parameter int WORD_W = sine_ctrl_pkg::WORD_W,
  parameter int ADDR_W = sine_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
`ifdef SINE_PHASE_INC_EN
  input  logic [7:0]        phase_inc,
`endif
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              SO,
  output logic              SI_en,
  output logic              soc,
  output logic              busy,
  output logic              wrap,
  output logic              overrun
);
`ifdef SINE_PHASE_INC_EN
  localparam int PTR_W = PHASE_W;
`else
  localparam int PTR_W = ADDR_W;
`endif

  state_e           state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W:0]   ptr_sum;
  logic             rom_en_q;
  logic             busy_q;
  logic             wrap_q;
  logic             overrun_q;
  logic             stop_pend_q;
  logic             last_bit;

`ifdef SINE_PHASE_INC_EN
  assign ptr_sum  = {1'b0, ptr_q} + {1'b0, phase_inc};
  assign rom_addr = ptr_q[PTR_W-1 -: ADDR_W];
`else
  assign ptr_sum  = {1'b0, ptr_q} + {{PTR_W{1'b0}}, 1'b1};
  assign rom_addr = ptr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      rom_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      overrun_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      rom_en_q <= 1'b0;
      wrap_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_q   <= S_ARMED;
            ptr_q     <= '0;
            overrun_q <= 1'b0;
          end
        end
        S_ARMED: begin
          if (stop) begin
            state_q <= S_IDLE;
          end else if (tick) begin
            state_q  <= S_FETCH;
            rom_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_FETCH: begin
          // Carry out of the step is the rollover indication.
          state_q <= S_WAIT;
          ptr_q   <= ptr_sum[PTR_W-1:0];
          wrap_q  <= ptr_sum[PTR_W];
        end
        S_WAIT: state_q <= S_SHIFT;
        S_SHIFT: begin
          if (last_bit) begin
            state_q     <= (stop_pend_q || stop) ? S_IDLE : S_ARMED;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (busy_q && tick) overrun_q <= 1'b1;
      if (busy_q && stop && !last_bit) stop_pend_q <= 1'b1;
    end
  end

  sine_piso #(.W(WORD_W)) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load_i   (state_q == S_WAIT),
    .data_i   (rom_data),
    .SO       (SO),
    .SI_en    (SI_en),
    .soc      (soc),
    .last_bit (last_bit)
  );

  assign rom_en  = rom_en_q;
  assign busy    = busy_q;
  assign wrap    = wrap_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_sine_stream_ctrl.sv
// Scoreboard bench for sine_stream_ctrl: fetch addresses and serial words checked against queues.
module tb_sine_stream_ctrl;
  logic        clk = 1'b0;
  logic        rst, tick, start, stop;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic        SO, SI_en, soc, busy, wrap, overrun;
`ifdef SINE_PHASE_INC_EN
  logic [7:0]  phase_inc;
`endif

  logic [31:0] rom [64];
  int          checks = 0;
  int          failures = 0;
  int          wrap_cnt = 0;
  int          nbits = 0;
  logic [31:0] cur = '0;
  bit          allow_trunc = 1'b0;
  int          exp_addr_q[$];
  logic [31:0] exp_word_q[$];

  sine_stream_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
`ifdef SINE_PHASE_INC_EN
    .phase_inc(phase_inc),
`endif
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .SO(SO), .SI_en(SI_en), .soc(soc), .busy(busy), .wrap(wrap), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: fetch addresses and completed serial words against the scoreboard.
  always @(negedge clk) begin
    if (wrap) wrap_cnt++;
    if (rom_en) begin
      if (exp_addr_q.size() == 0) check_val("spurious_fetch", {31'd0, rom_en}, 32'd0);
      else check_val("fetch_addr", {26'd0, rom_addr}, exp_addr_q.pop_front());
    end
    if (SI_en) begin
      check_val("soc_pos", {31'd0, soc}, {31'd0, (nbits == 0)});
      cur = {cur[30:0], SO};
      nbits++;
      if (nbits == 32) begin
        if (exp_word_q.size() == 0) check_val("spurious_word", cur, 32'hxxxx_xxxx);
        else check_val("word", cur, exp_word_q.pop_front());
        nbits = 0;
      end
    end else if (nbits != 0) begin
      if (!allow_trunc) check_val("word_len", nbits, 32);
      nbits = 0;
    end
  end

  // One tick at cycle T (driven mid-cycle), then 35 cycles of timed checks and injections.
  task automatic tick_word(input int a, input bit exp_wrap, input int tick_at,
                           input int stop_at, input int rst_at);
    int si_cnt = 0;
    exp_addr_q.push_back(a);
    if (rst_at < 0) exp_word_q.push_back(rom[a]);
    @(negedge clk); tick = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      tick = (k == tick_at);
      stop = (k == stop_at);
      rst  = (k == rst_at);
      if (SI_en) si_cnt++;
      if (k == 1) check_val("fetch_t1", {30'd0, rom_en, busy}, 32'd3);
      if (k == 2) check_val("wrap_t2", {31'd0, wrap}, {31'd0, exp_wrap});
      if (k == 3) check_val("soc_t3", {30'd0, soc, SI_en}, 32'd3);
      if (tick_at > 0 && k == tick_at + 1) check_val("overrun_set", {31'd0, overrun}, 32'd1);
      if (rst_at > 0 && k == rst_at + 1)
        check_val("rst_outs", {rom_en, SO, SI_en, soc, busy, wrap, overrun, rom_addr}, 32'd0);
      if (rst_at < 0 && k == 34) check_val("last_bit_t34", {30'd0, busy, SI_en}, 32'd3);
      if (rst_at < 0 && k == 35) check_val("end_t35", {29'd0, busy, SI_en, SO}, 32'd0);
    end
    if (rst_at < 0) check_val("si_len", si_cnt, 32);
    repeat (3) @(negedge clk);
  endtask

  task automatic no_fetch_tick(input string tag);
    int n = 0;
    @(negedge clk); tick = 1'b1;
    repeat (6) begin
      @(negedge clk); tick = 1'b0;
      if (rom_en || busy) n++;
    end
    check_val(tag, n, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef SINE_PHASE_INC_EN
    phase_inc = 8'd0;
`endif
    rom[0] = 32'hA5A5_0001;
    for (int i = 1; i < 64; i++) rom[i] = $urandom;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_outs", {rom_en, SO, SI_en, soc, busy, wrap, overrun, rom_addr}, 32'd0);
    no_fetch_tick("idle_tick_ignored");

`ifndef SINE_PHASE_INC_EN
    // Full address sweep with rollover.
    pulse_start();
    wrap_cnt = 0;
    for (int a = 0; a < 64; a++) tick_word(a, (a == 63), -1, -1, -1);
    tick_word(0, 1'b0, -1, -1, -1);
    check_val("wrap_count", wrap_cnt, 1);

    // Tick inside a word is dropped and flags overrun.
    tick_word(1, 1'b0, 10, -1, -1);
    tick_word(2, 1'b0, -1, -1, -1);
    check_val("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Stop mid-word: word completes, then idle.
    tick_word(3, 1'b0, -1, 20, -1);
    no_fetch_tick("stopped_no_fetch");

    // Start and stop together in IDLE: stop wins.
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    no_fetch_tick("start_stop_no_fetch");
    check_val("overrun_kept", {31'd0, overrun}, 32'd1);

    pulse_start();
    check_val("overrun_cleared", {31'd0, overrun}, 32'd0);
    tick_word(0, 1'b0, -1, -1, -1);

    // Tick and stop together in ARMED: no fetch, back to IDLE.
    @(negedge clk); tick = 1'b1; stop = 1'b1;
    @(negedge clk); tick = 1'b0; stop = 1'b0;
    no_fetch_tick("tick_stop_no_fetch");

    // Reset mid-word discards the word; replay starts at address 0.
    pulse_start();
    tick_word(0, 1'b0, -1, -1, -1);
    allow_trunc = 1'b1;
    tick_word(1, 1'b0, -1, -1, 15);
    allow_trunc = 1'b0;
    no_fetch_tick("after_rst_idle");
    pulse_start();
    tick_word(0, 1'b0, -1, -1, -1);
    tick_word(1, 1'b0, -1, -1, -1);
`else
    // Phase step of 8 advances the ROM address by 2 per word.
    phase_inc = 8'd8;
    pulse_start();
    wrap_cnt = 0;
    for (int n = 0; n < 32; n++) tick_word(2 * n, (n == 31), -1, -1, -1);
    check_val("phase_wrap_count", wrap_cnt, 1);
    tick_word(0, 1'b0, -1, -1, -1);
`endif

    check_val("scoreboard_empty", exp_addr_q.size() + exp_word_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
